// File: rtl/alu_bcd_scan_display_pkg.sv
// Shared types and constants for the registered ALU / BCD / scanned 7-segment display block.
// Holds op codes, FSM states, segment patterns and the BCD glyph table.
package alu_bcd_scan_display_pkg;

    typedef enum logic [1:0] {
        OP_AND = 2'b00,
        OP_ADD = 2'b01,
        OP_SHL = 2'b10,
        OP_MUL = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_CONV = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // Segment order is {a,b,c,d,e,f,g}; a 1 lights the segment.
    localparam logic [6:0] SEG_BLANK = 7'b0000000;
    localparam logic [6:0] SEG_DASH  = 7'b0000001;

    function automatic logic [6:0] bcd_glyph(input logic [3:0] digit);
        logic [6:0] glyph;
        case (digit)
            4'd0:    glyph = 7'b1111110;
            4'd1:    glyph = 7'b0110000;
            4'd2:    glyph = 7'b1101101;
            4'd3:    glyph = 7'b1111001;
            4'd4:    glyph = 7'b0110011;
            4'd5:    glyph = 7'b1011011;
            4'd6:    glyph = 7'b1011111;
            4'd7:    glyph = 7'b1110000;
            4'd8:    glyph = 7'b1111111;
            4'd9:    glyph = 7'b1111011;
            default: glyph = SEG_BLANK;
        endcase
        return glyph;
    endfunction

endpackage

// File: rtl/alu_bcd_scan_display_seg7_decode.sv
// Combinational BCD digit to seven-segment decoder with a blanking input.
// Non-decimal nibbles render blank.
module seg7_decode
    import alu_bcd_scan_display_pkg::*;
(
    input  logic [3:0] bcd,
    input  logic       blank,
    output logic [6:0] seg
);

    always_comb begin
        seg = blank ? SEG_BLANK : bcd_glyph(bcd);
    end

endmodule

// File: rtl/alu_bcd_scan_display.sv
// Registered 4-op ALU feeding a sequential double-dabble BCD converter and a
// free-running multiplexed seven-segment display with blanking and overflow dashes.
module alu_bcd_scan_display
    import alu_bcd_scan_display_pkg::*;
#(
    parameter int W        = 4,
    parameter int DIGITS   = 3,
    parameter int SCAN_DIV = 50000
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [W-1:0]   A,
    input  logic [W-1:0]   B,
    input  logic [1:0]     S,
    input  logic           start,
    output logic           busy,
    output logic           done,
    output logic [2*W-1:0] result,
    output logic [6:0]     seg,
    output logic [2:0]     DE,
    output logic           led
);

    localparam int RW     = 2 * W;
    localparam int BW     = 4 * DIGITS;
    localparam int CNT_W  = $clog2(RW + 1);
    localparam int SCAN_W = $clog2(SCAN_DIV);

    state_e            state_q,  state_d;
    logic [W-1:0]      a_q,      a_d;
    logic [W-1:0]      b_q,      b_d;
    op_e               op_q,     op_d;
    logic [RW-1:0]     result_q, result_d;
    logic [BW-1:0]     bcd_q,    bcd_d;
    logic [RW-1:0]     bin_q,    bin_d;
    logic [CNT_W-1:0]  bits_q,   bits_d;
    logic              ovf_q,    ovf_d;
    logic [BW-1:0]     disp_q,   disp_d;
    logic              led_q,    led_d;
    logic              valid_q,  valid_d;
    logic [SCAN_W-1:0] scan_q,   scan_d;
    logic [2:0]        idx_q,    idx_d;

    logic [RW-1:0]     alu_res;
    logic [BW-1:0]     bcd_adj;
    logic [3:0]        cur_digit;
    logic              upper_nonzero;
    logic              digit_blank;
    logic [6:0]        digit_seg;

    always_comb begin
        case (op_q)
            OP_AND:  alu_res = RW'(a_q & b_q);
            OP_ADD:  alu_res = RW'(a_q) + RW'(b_q);
            OP_SHL:  alu_res = RW'(a_q) << 1;
            default: alu_res = RW'(a_q) * RW'(b_q);
        endcase
    end

    // Double-dabble correction: any nibble that would reach 10 after the shift gets +3 first.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        result_d = result_q;
        bcd_d    = bcd_q;
        bin_d    = bin_q;
        bits_d   = bits_q;
        ovf_d    = ovf_q;
        disp_d   = disp_q;
        led_d    = led_q;
        valid_d  = valid_q;
        busy     = 1'b0;
        done     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_d     = A;
                    b_d     = B;
                    op_d    = op_e'(S);
                    state_d = ST_CALC;
                end
            end
            ST_CALC: begin
                busy     = 1'b1;
                result_d = alu_res;
                bin_d    = alu_res;
                bcd_d    = '0;
                bits_d   = CNT_W'(RW);
                ovf_d    = 1'b0;
                state_d  = ST_CONV;
            end
            ST_CONV: begin
                busy   = 1'b1;
                bcd_d  = {bcd_adj[BW-2:0], bin_q[RW-1]};
                bin_d  = {bin_q[RW-2:0], 1'b0};
                ovf_d  = ovf_q | bcd_adj[BW-1];
                bits_d = bits_q - CNT_W'(1);
                if (bits_q == CNT_W'(1)) begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                done    = 1'b1;
                disp_d  = bcd_q;
                led_d   = ovf_q;
                valid_d = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
    end

    // The scan runs regardless of the FSM so the display never flickers during a conversion.
    always_comb begin
        scan_d = scan_q + SCAN_W'(1);
        idx_d  = idx_q;
        if (scan_q == SCAN_W'(SCAN_DIV - 1)) begin
            scan_d = '0;
            idx_d  = (idx_q == 3'(DIGITS - 1)) ? 3'd0 : idx_q + 3'd1;
        end
    end

    always_comb begin
        cur_digit     = 4'd0;
        upper_nonzero = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == 3'(i)) begin
                cur_digit = disp_q[4*i +: 4];
            end
            if (3'(i) >= idx_q && disp_q[4*i +: 4] != 4'd0) begin
                upper_nonzero = 1'b1;
            end
        end
        digit_blank = !valid_q || (idx_q != 3'd0 && !upper_nonzero);
    end

    seg7_decode u_seg7_decode (
        .bcd   (cur_digit),
        .blank (digit_blank),
        .seg   (digit_seg)
    );

    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    // NOTE: the display registers are reset too, so the display comes up blank after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= OP_AND;
            result_q <= '0;
            bcd_q    <= '0;
            bin_q    <= '0;
            bits_q   <= '0;
            ovf_q    <= 1'b0;
            disp_q   <= '0;
            led_q    <= 1'b0;
            valid_q  <= 1'b0;
            scan_q   <= '0;
            idx_q    <= 3'd0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            result_q <= result_d;
            bcd_q    <= bcd_d;
            bin_q    <= bin_d;
            bits_q   <= bits_d;
            ovf_q    <= ovf_d;
            disp_q   <= disp_d;
            led_q    <= led_d;
            valid_q  <= valid_d;
            scan_q   <= scan_d;
            idx_q    <= idx_d;
        end
    end

    assign result = result_q;
    assign DE     = idx_q;
    assign led    = led_q;
    assign seg    = (valid_q && led_q) ? SEG_DASH : digit_seg;

endmodule
